uart_frame_parser: RTL

- Consumes the received-byte stream of the UART/FIFO bridge (rcv_data, recv_done).
- Delimits framed commands: header 0xA5, cmd, len, payload[len], checksum.
- Streams validated fields to the command logic.
- Emits a one-byte ACK/NAK reply on tx_data/tx_valid, which feeds the bridge's send_data/recv_valid input.

---
 rtl/uart_frame_parser_if.sv | 28 ++
 rtl/uart_frame_parser.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/uart_frame_parser_if.sv
// Byte-stream input and decoded-field/reply outputs of the UART frame parser.
// The slave modport is the parser; the master modport is the bridge/command side.
interface uart_frame_parser_if;
  logic [7:0]  rcv_data;
  logic        recv_done;
  logic [7:0]  cmd;
  logic [7:0]  pl_data;
  logic        pl_valid;
  logic [7:0]  pl_index;
  logic        frame_ok;
  logic        frame_err;
  logic [1:0]  err_code;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic [15:0] ok_count;

  modport master (
    output rcv_data, recv_done,
    input  cmd, pl_data, pl_valid, pl_index, frame_ok, frame_err,
    input  err_code, tx_data, tx_valid, ok_count
  );

  modport slave (
    input  rcv_data, recv_done,
    output cmd, pl_data, pl_valid, pl_index, frame_ok, frame_err,
    output err_code, tx_data, tx_valid, ok_count
  );
endinterface

// File: rtl/uart_frame_parser.sv
// Parses A5/cmd/len/payload/checksum frames from the UART byte stream,
// streams payload bytes out and answers every finished frame with ACK or NAK.
module uart_frame_parser #(
  parameter int         MAX_LEN        = 16,
  parameter int         TIMEOUT_CYCLES = 500000,
  parameter logic [7:0] HEADER         = 8'hA5,
  parameter logic [7:0] ACK_BYTE       = 8'h06,
  parameter logic [7:0] NAK_BYTE       = 8'h15
) (
  input logic                clk,
  input logic                reset,
  uart_frame_parser_if.slave bus
);
  localparam int            TW         = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [7:0]    MAX_LEN_B  = 8'(MAX_LEN);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, CMD, LEN, PAYLOAD, CSUM} state_t;

  state_t         state_reg, state_next;
  logic           recv_done_q;
  logic           ev;
  logic [7:0]     sum_reg, sum_next;
  logic [7:0]     len_reg, len_next;
  logic [7:0]     idx_reg, idx_next;
  logic [TW-1:0]  timer_reg, timer_next;
  logic [7:0]     cmd_reg, cmd_next;
  logic [7:0]     pl_data_reg, pl_data_next;
  logic [7:0]     pl_index_reg, pl_index_next;
  logic           pl_valid_reg, pl_valid_next;
  logic           frame_ok_reg, frame_ok_next;
  logic           frame_err_reg, frame_err_next;
  logic [1:0]     err_code_reg, err_code_next;
  logic [7:0]     tx_data_reg, tx_data_next;
  logic           tx_valid_reg, tx_valid_next;
  logic [15:0]    ok_count_reg, ok_count_next;

  // A strobe held high for several cycles still yields a single byte event.
  assign ev = bus.recv_done & ~recv_done_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      recv_done_q   <= 1'b0;
      sum_reg       <= '0;
      len_reg       <= '0;
      idx_reg       <= '0;
      timer_reg     <= '0;
      cmd_reg       <= '0;
      pl_data_reg   <= '0;
      pl_index_reg  <= '0;
      pl_valid_reg  <= 1'b0;
      frame_ok_reg  <= 1'b0;
      frame_err_reg <= 1'b0;
      err_code_reg  <= '0;
      tx_data_reg   <= '0;
      tx_valid_reg  <= 1'b0;
      ok_count_reg  <= '0;
    end else begin
      state_reg     <= state_next;
      recv_done_q   <= bus.recv_done;
      sum_reg       <= sum_next;
      len_reg       <= len_next;
      idx_reg       <= idx_next;
      timer_reg     <= timer_next;
      cmd_reg       <= cmd_next;
      pl_data_reg   <= pl_data_next;
      pl_index_reg  <= pl_index_next;
      pl_valid_reg  <= pl_valid_next;
      frame_ok_reg  <= frame_ok_next;
      frame_err_reg <= frame_err_next;
      err_code_reg  <= err_code_next;
      tx_data_reg   <= tx_data_next;
      tx_valid_reg  <= tx_valid_next;
      ok_count_reg  <= ok_count_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    sum_next       = sum_reg;
    len_next       = len_reg;
    idx_next       = idx_reg;
    cmd_next       = cmd_reg;
    pl_data_next   = pl_data_reg;
    pl_index_next  = pl_index_reg;
    pl_valid_next  = 1'b0;
    frame_ok_next  = 1'b0;
    frame_err_next = 1'b0;
    err_code_next  = err_code_reg;
    tx_data_next   = tx_data_reg;
    tx_valid_next  = 1'b0;
    ok_count_next  = ok_count_reg;

    // A byte arriving on the expiry cycle takes precedence over the timeout.
    if (ev) begin
      unique case (state_reg)
        IDLE: begin
          if (bus.rcv_data == HEADER) state_next = CMD;
        end
        CMD: begin
          cmd_next   = bus.rcv_data;
          sum_next   = bus.rcv_data;
          state_next = LEN;
        end
        LEN: begin
          if (bus.rcv_data > MAX_LEN_B) begin
            frame_err_next = 1'b1;
            err_code_next  = 2'd1;
            tx_data_next   = NAK_BYTE;
            tx_valid_next  = 1'b1;
            state_next     = IDLE;
          end else begin
            len_next   = bus.rcv_data;
            sum_next   = sum_reg + bus.rcv_data;
            idx_next   = '0;
            state_next = (bus.rcv_data == 8'd0) ? CSUM : PAYLOAD;
          end
        end
        PAYLOAD: begin
          pl_data_next  = bus.rcv_data;
          pl_index_next = idx_reg;
          pl_valid_next = 1'b1;
          sum_next      = sum_reg + bus.rcv_data;
          idx_next      = idx_reg + 8'd1;
          if (idx_reg == len_reg - 8'd1) state_next = CSUM;
        end
        CSUM: begin
          tx_valid_next = 1'b1;
          state_next    = IDLE;
          if (bus.rcv_data == sum_reg) begin
            frame_ok_next = 1'b1;
            err_code_next = 2'd0;
            tx_data_next  = ACK_BYTE;
            ok_count_next = ok_count_reg + 16'd1;
          end else begin
            frame_err_next = 1'b1;
            err_code_next  = 2'd2;
            tx_data_next   = NAK_BYTE;
          end
        end
        default: state_next = IDLE;
      endcase
    end else if (state_reg != IDLE && timer_reg == TIMER_LAST) begin
      frame_err_next = 1'b1;
      err_code_next  = 2'd3;
      tx_data_next   = NAK_BYTE;
      tx_valid_next  = 1'b1;
      state_next     = IDLE;
    end

    timer_next = (ev || state_next == IDLE) ? '0 : timer_reg + 1'b1;
  end

  assign bus.cmd       = cmd_reg;
  assign bus.pl_data   = pl_data_reg;
  assign bus.pl_valid  = pl_valid_reg;
  assign bus.pl_index  = pl_index_reg;
  assign bus.frame_ok  = frame_ok_reg;
  assign bus.frame_err = frame_err_reg;
  assign bus.err_code  = err_code_reg;
  assign bus.tx_data   = tx_data_reg;
  assign bus.tx_valid  = tx_valid_reg;
  assign bus.ok_count  = ok_count_reg;
endmodule
